// File: rtl/vme_cfg_loader_pkg.sv
// Shared definitions for the VME-driven Xilinx slave-serial configuration loader:
// register sub-addresses, CSR/status bit positions and the sequencer state encoding.
package vme_cfg_loader_pkg;

  localparam logic [3:0] ADDR_CSR  = 4'h0;
  localparam logic [3:0] ADDR_DATA = 4'h1;

  localparam int CSR_START = 0;
  localparam int CSR_ABORT = 1;
  localparam int CSR_CLEAR = 2;

  localparam int ST_INIT = 0;
  localparam int ST_DONE = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_FULL = 3;
  localparam int ST_ERR  = 4;
  localparam int ST_OVR  = 5;

  // INIT_S still shows pre-release levels for this many cycles after PROG_B rises
  localparam int INIT_BLANK = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PROG  = 3'd1,
    S_WAITI = 3'd2,
    S_READY = 3'd3,
    S_SHIFT = 3'd4
  } state_t;

endpackage

// File: rtl/vme_cfg_loader_if.sv
// Byte-wide register write/read bus between the VME A16 slave and the loader.
// Handshake: WSTB is a single-cycle write strobe qualifying WADDR/WDATA; there is
// no back-pressure, every strobe is consumed in its cycle. RDATA follows RADDR combinationally.
interface vme_cfg_loader_if;
  logic       WSTB;
  logic [3:0] WADDR;
  logic [7:0] WDATA;
  logic [3:0] RADDR;
  logic [7:0] RDATA;

  modport master (output WSTB, WADDR, WDATA, RADDR, input RDATA);
  modport slave  (input WSTB, WADDR, WDATA, RADDR, output RDATA);
endinterface

// File: rtl/vme_cfg_loader_shifter.sv
// MSB-first byte serialiser generating CCLK/DIN. A byte is taken when load && ready;
// ready is high when idle and also in the final cycle of bit 0, so bytes chain with no gap.
module vme_cfg_loader_shifter #(
  parameter int CCLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       abort,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       last,
  output logic       cclk,
  output logic       din
);

  localparam int DW = (CCLK_DIV > 1) ? $clog2(CCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CCLK_DIV - 1);

  logic [7:0]    sr;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic          hi;
  logic          act;

  assign last  = act && hi && (div_cnt == DIV_LAST) && (bit_cnt == 3'd7);
  assign ready = !act || last;
  assign cclk  = hi;
  assign din   = sr[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      hi      <= 1'b0;
      act     <= 1'b0;
    end else if (abort) begin
      sr      <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      hi      <= 1'b0;
      act     <= 1'b0;
    end else if (load && ready) begin
      sr      <= data;
      bit_cnt <= '0;
      div_cnt <= '0;
      hi      <= 1'b0;
      act     <= 1'b1;
    end else if (act) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        hi      <= ~hi;
        // Falling edge of CCLK: advance to the next bit
        if (hi) begin
          sr      <= {sr[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) act <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vme_cfg_loader.sv
// Register front end and configuration sequencer: PROG_B pulse, INIT_B wait,
// one-byte holding buffer feeding the serialiser, status byte for VME reads.
module vme_cfg_loader
  import vme_cfg_loader_pkg::*;
#(
  parameter int CCLK_DIV     = 2,
  parameter int PROG_CYCLES  = 64,
  parameter int INIT_TIMEOUT = 4096
) (
  input  logic                   CPLDCLK,
  input  logic                   CRSTN,
  vme_cfg_loader_if.slave        bus,
  output logic                   PROGN,
  output logic                   CCLK,
  output logic                   DIN,
  input  logic                   INITN,
  input  logic                   DONE,
  output state_t                 dbg_state
);

  localparam int CNT_MAX = (PROG_CYCLES > INIT_TIMEOUT) ? PROG_CYCLES : INIT_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [1:0]    init_sync, done_sync;
  logic          init_s, done_s;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [7:0]    buf_q, last_data, status;
  logic          buf_full, err, ovr, err_pend, err_pend_nx, err_set;
  logic          csr_wr, data_wr, start, abort, clear;
  logic          feeding, load, bypass, drain, buf_wr, drop;
  logic          sh_ready, sh_last;

  always_ff @(posedge CPLDCLK or negedge CRSTN) begin
    if (!CRSTN) begin
      init_sync <= '0;
      done_sync <= '0;
    end else begin
      init_sync <= {init_sync[0], INITN};
      done_sync <= {done_sync[0], DONE};
    end
  end

  assign init_s = init_sync[1];
  assign done_s = done_sync[1];

  always_comb begin
    csr_wr  = bus.WSTB && (bus.WADDR == ADDR_CSR);
    data_wr = bus.WSTB && (bus.WADDR == ADDR_DATA);
    abort   = csr_wr && bus.WDATA[CSR_ABORT];
    start   = csr_wr && bus.WDATA[CSR_START] && !abort;
    clear   = csr_wr && bus.WDATA[CSR_CLEAR];
    feeding = ((state == S_READY) || (state == S_SHIFT)) && !abort;
    // No new byte starts once INIT_B has signalled a CRC error
    load    = feeding && !err_pend && init_s && sh_ready && (buf_full || data_wr);
    bypass  = load && !buf_full;
    drain   = load && buf_full;
    buf_wr  = data_wr && feeding && !bypass && (!buf_full || drain);
    drop    = data_wr && !bypass && !buf_wr;
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    err_set     = 1'b0;
    err_pend_nx = err_pend;
    case (state)
      S_IDLE: begin
        err_pend_nx = 1'b0;
        if (start) begin
          state_nx = S_PROG;
          cnt_nx   = '0;
        end
      end
      S_PROG: begin
        if (cnt == CW'(PROG_CYCLES - 1)) begin
          state_nx = S_WAITI;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_WAITI: begin
        if (init_s && (cnt >= CW'(INIT_BLANK))) begin
          state_nx = S_READY;
        end else if (cnt == CW'(INIT_TIMEOUT - 1)) begin
          err_set  = 1'b1;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_READY: begin
        if (!init_s) begin
          err_set  = 1'b1;
          state_nx = S_IDLE;
        end else if (load) begin
          state_nx = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!init_s) begin
          err_set     = 1'b1;
          err_pend_nx = 1'b1;
        end
        if (sh_last && !load) state_nx = err_pend_nx ? S_IDLE : S_READY;
      end
      default: state_nx = S_IDLE;
    endcase
    if (abort) begin
      state_nx    = S_IDLE;
      err_pend_nx = 1'b0;
    end
  end

  always_ff @(posedge CPLDCLK or negedge CRSTN) begin
    if (!CRSTN) begin
      state     <= S_IDLE;
      cnt       <= '0;
      err_pend  <= 1'b0;
      buf_q     <= '0;
      buf_full  <= 1'b0;
      last_data <= '0;
      err       <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      err_pend <= err_pend_nx;
      if (state_nx == S_IDLE) begin
        buf_full <= 1'b0;
      end else if (buf_wr) begin
        buf_q    <= bus.WDATA;
        buf_full <= 1'b1;
      end else if (drain) begin
        buf_full <= 1'b0;
      end
      if (data_wr) last_data <= bus.WDATA;
      if (err_set)    err <= 1'b1;
      else if (clear) err <= 1'b0;
      if (drop)       ovr <= 1'b1;
      else if (clear) ovr <= 1'b0;
    end
  end

  vme_cfg_loader_shifter #(.CCLK_DIV(CCLK_DIV)) u_shifter (
    .clk   (CPLDCLK),
    .rst_n (CRSTN),
    .abort (abort),
    .load  (load),
    .data  (buf_full ? buf_q : bus.WDATA),
    .ready (sh_ready),
    .last  (sh_last),
    .cclk  (CCLK),
    .din   (DIN)
  );

  assign PROGN     = (state != S_PROG);
  assign dbg_state = state;

  always_comb begin
    status          = '0;
    status[ST_INIT] = init_s;
    status[ST_DONE] = done_s;
    status[ST_BUSY] = (state == S_PROG) || (state == S_WAITI) || (state == S_SHIFT);
    status[ST_FULL] = buf_full;
    status[ST_ERR]  = err;
    status[ST_OVR]  = ovr;
    case (bus.RADDR)
      ADDR_CSR:  bus.RDATA = status;
      ADDR_DATA: bus.RDATA = last_data;
      default:   bus.RDATA = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_vme_cfg_loader.sv
// Directed bench for vme_cfg_loader: register table in IDLE, then hand-written
// sequences for configuration start, byte streaming, overrun, errors, abort and reset.
module tb_vme_cfg_loader;
  import vme_cfg_loader_pkg::*;

  localparam int CCLK_DIV     = 2;
  localparam int PROG_CYCLES  = 64;
  localparam int INIT_TIMEOUT = 4096;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   progn, cclk, din;
  logic   initn = 1'b1;
  logic   done = 1'b0;
  state_t dbg_state;

  vme_cfg_loader_if bus();

  vme_cfg_loader #(
    .CCLK_DIV     (CCLK_DIV),
    .PROG_CYCLES  (PROG_CYCLES),
    .INIT_TIMEOUT (INIT_TIMEOUT)
  ) dut (
    .CPLDCLK   (clk),
    .CRSTN     (rst_n),
    .bus       (bus),
    .PROGN     (progn),
    .CCLK      (cclk),
    .DIN       (din),
    .INITN     (initn),
    .DONE      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  int         rise_cyc[$];
  logic       mon_en = 1'b0;
  logic       cclk_prev = 1'b0;
  logic [7:0] mon_byte = '0;
  int         mon_bits = 0;

  // Rebuild bytes from DIN at each CCLK rise and compare against the expected queue
  always @(posedge clk) begin
    #1;
    if (mon_en && rst_n && cclk && !cclk_prev) begin
      rise_cyc.push_back(cyc);
      mon_byte = {mon_byte[6:0], din};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", mon_byte);
        end else begin
          chk("shifted_byte", mon_byte, exp_q.pop_front());
        end
      end
    end
    if (!mon_en || !rst_n) mon_bits = 0;
    cclk_prev = cclk;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.WADDR = a;
    bus.WDATA = d;
    bus.WSTB  = 1'b1;
    tick(1);
    bus.WSTB  = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    bus.RADDR = a;
    #1;
    d = bus.RDATA;
  endtask

  task automatic wait_state(input state_t st, input int budget, input string name);
    int n = 0;
    while (dbg_state != st && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, dbg_state, st);
  endtask

  task automatic wait_progn_high(input int budget, output int n);
    n = 0;
    while (progn == 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  // ---------------- register vectors in IDLE ----------------
  typedef struct {
    logic       do_wr;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic       done_lvl;
    logic [3:0] raddr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0] st;
    int         n;
    int         c1;
    int         bad;

    vecs[0] = '{1'b1, 4'h5, 8'hFF, 1'b0, 4'h0, 8'h01};  // unmapped write ignored
    vecs[1] = '{1'b1, 4'h1, 8'h5A, 1'b0, 4'h0, 8'h21};  // DATA in IDLE dropped -> OVR
    vecs[2] = '{1'b0, 4'h0, 8'h00, 1'b0, 4'h1, 8'h5A};  // last DATA byte
    vecs[3] = '{1'b0, 4'h0, 8'h00, 1'b0, 4'h9, 8'h00};  // unmapped read
    vecs[4] = '{1'b1, 4'h0, 8'h04, 1'b0, 4'h0, 8'h01};  // clear flags
    vecs[5] = '{1'b1, 4'h0, 8'h03, 1'b0, 4'h0, 8'h01};  // abort beats start
    vecs[6] = '{1'b0, 4'h0, 8'h00, 1'b1, 4'h0, 8'h03};  // DONE synced into status
    vecs[7] = '{1'b1, 4'h1, 8'hC3, 1'b1, 4'h1, 8'hC3};
    vecs[8] = '{1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h21};
    vecs[9] = '{1'b1, 4'h0, 8'h04, 1'b0, 4'h0, 8'h01};

    bus.WSTB  = 1'b0;
    bus.WADDR = '0;
    bus.WDATA = '0;
    bus.RADDR = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_progn", progn, 1);
    chk("reset_cclk", cclk, 0);
    rst_n = 1'b1;
    tick(3);
    chk("reset_state", dbg_state, S_IDLE);
    chk("reset_din", din, 0);
    rd(4'h0, st);
    chk("reset_status", st, 8'h01);

    for (int i = 0; i < 10; i++) begin
      done = vecs[i].done_lvl;
      if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdata);
      tick(3);
      rd(vecs[i].raddr, st);
      chk($sformatf("reg_vec%0d_rdata", i), st, vecs[i].exp);
      chk($sformatf("reg_vec%0d_idle", i), dbg_state, S_IDLE);
    end

    // Start with INIT_B high: PROG_B pulse width, then READY
    wr(4'h0, 8'h01);
    rd(4'h0, st);
    chk("prog_status_busy", st, 8'h05);
    wait_progn_high(100, n);
    chk("prog_low_cycles", n, PROG_CYCLES);
    n = 0;
    while (dbg_state != S_READY && n < 10) begin
      tick(1);
      n++;
    end
    chk("ready_latency_2_to_3", (n >= 2 && n <= 3), 1);
    rd(4'h0, st);
    chk("ready_status", st, 8'h01);

    // Back-to-back bytes: first bypasses the buffer, second chains with no gap
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    rise_cyc.delete();
    mon_en = 1'b1;
    wr(4'h1, 8'hA5);
    c1 = cyc;
    chk("first_bit_din", din, 1);
    chk("first_bit_cclk_low", cclk, 0);
    chk("shift_state", dbg_state, S_SHIFT);
    wr(4'h1, 8'h3C);
    rd(4'h0, st);
    chk("buffered_status", st, 8'h0D);
    n = 0;
    while (rise_cyc.size() < 16 && n < 100) begin
      tick(1);
      n++;
    end
    chk("rise_count", rise_cyc.size(), 16);
    if (rise_cyc.size() >= 16) begin
      chk("first_rise_latency", rise_cyc[0] - c1, CCLK_DIV);
      chk("byte_time", rise_cyc[8] - rise_cyc[0], 16 * CCLK_DIV);
      bad = 0;
      for (int i = 0; i < 15; i++)
        if (rise_cyc[i+1] - rise_cyc[i] != 2 * CCLK_DIV) bad++;
      chk("rise_gaps", bad, 0);
    end
    wait_state(S_READY, 10, "back_to_back_ready");
    chk("back_to_back_drained", exp_q.size(), 0);

    // Three writes inside one byte time: third is dropped
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    wr(4'h1, 8'h11);
    wr(4'h1, 8'h22);
    wr(4'h1, 8'h33);
    wr(4'h0, 8'h01);
    chk("start_ignored_state", dbg_state, S_SHIFT);
    chk("start_ignored_progn", progn, 1);
    rd(4'h0, st);
    chk("overrun_status", st, 8'h2D);
    tick(2);
    wait_state(S_READY, 100, "overrun_ready");
    rd(4'h0, st);
    chk("overrun_kept", st, 8'h21);
    rd(4'h1, st);
    chk("last_data_dropped_byte", st, 8'h33);
    wr(4'h0, 8'h04);
    rd(4'h0, st);
    chk("overrun_cleared", st, 8'h01);
    chk("overrun_drained", exp_q.size(), 0);

    // Abort with start in the same write during SHIFT and a full buffer
    mon_en = 1'b0;
    wr(4'h1, 8'h96);
    wr(4'h1, 8'h69);
    tick(5);
    wr(4'h0, 8'h03);
    chk("abort_state", dbg_state, S_IDLE);
    chk("abort_cclk", cclk, 0);
    rd(4'h0, st);
    chk("abort_status", st, 8'h01);

    // INIT_B held low: timeout flags ERR
    initn = 1'b0;
    tick(3);
    wr(4'h0, 8'h01);
    wait_progn_high(100, n);
    n = 0;
    rd(4'h0, st);
    while (!st[ST_ERR] && n < 5000) begin
      tick(1);
      n++;
      rd(4'h0, st);
    end
    chk("init_timeout_cycles", n, INIT_TIMEOUT);
    chk("init_timeout_state", dbg_state, S_IDLE);
    chk("init_timeout_status", st, 8'h10);
    initn = 1'b1;
    wr(4'h0, 8'h04);
    tick(3);
    rd(4'h0, st);
    chk("err_cleared", st, 8'h01);

    // INIT_B pulse during SHIFT: byte finishes, buffered byte is not sent
    wr(4'h0, 8'h01);
    wait_state(S_READY, 100, "crc_ready");
    exp_q.push_back(8'hF0);
    mon_en = 1'b1;
    wr(4'h1, 8'hF0);
    wr(4'h1, 8'h0F);
    tick(5);
    initn = 1'b0;
    tick(1);
    initn = 1'b1;
    tick(3);
    rd(4'h0, st);
    chk("crc_err_set", st[ST_ERR], 1);
    chk("crc_still_shift", dbg_state, S_SHIFT);
    wait_state(S_IDLE, 60, "crc_idle");
    tick(4);
    chk("crc_byte_completed", exp_q.size(), 0);
    rd(4'h0, st);
    chk("crc_status", st, 8'h11);
    wr(4'h0, 8'h04);

    // Reset while CCLK is high mid-byte
    mon_en = 1'b0;
    wr(4'h0, 8'h01);
    wait_state(S_READY, 100, "rst_ready");
    wr(4'h1, 8'hFF);
    n = 0;
    while (cclk == 1'b0 && n < 20) begin
      tick(1);
      n++;
    end
    chk("pre_reset_cclk", cclk, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_cclk", cclk, 0);
    chk("async_reset_progn", progn, 1);
    chk("async_reset_din", din, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(3);
    chk("post_reset_state", dbg_state, S_IDLE);
    rd(4'h0, st);
    chk("post_reset_status", st, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
